// File: rtl/exec_unit_if.sv
// Issue-side and result-side handshake bundle between the reservation station,
// one functional-unit slot and the result bus.
interface exec_unit_if;
  logic        issue_valid;
  logic        issue_is_LS;
  logic        issue_alusrc;
  logic [3:0]  issue_alu_type;
  logic [5:0]  issue_rd_tag;
  logic [5:0]  issue_rob_num;
  logic [31:0] issue_rs1_val;
  logic [31:0] issue_rs2_val;
  logic [31:0] issue_imm;

  logic        fu_ready;
  logic        res_valid;
  logic        res_ready;
  logic [5:0]  res_tag;
  logic [5:0]  res_rob_num;
  logic [31:0] res_val;
  logic        res_is_LS;
  logic        drop_err;

  modport master (
    output issue_valid, issue_is_LS, issue_alusrc, issue_alu_type,
           issue_rd_tag, issue_rob_num, issue_rs1_val, issue_rs2_val, issue_imm,
           res_ready,
    input  fu_ready, res_valid, res_tag, res_rob_num, res_val, res_is_LS, drop_err
  );

  modport slave (
    input  issue_valid, issue_is_LS, issue_alusrc, issue_alu_type,
           issue_rd_tag, issue_rob_num, issue_rs1_val, issue_rs2_val, issue_imm,
           res_ready,
    output fu_ready, res_valid, res_tag, res_rob_num, res_val, res_is_LS, drop_err
  );
endinterface

// File: rtl/exec_unit.sv
// One FU slot: captures an issued op, computes an ALU result or LS address and
// holds it until the result bus accepts it. Define EXEC_MUL_EN for the iterative MUL.
module exec_unit #(
  parameter int MUL_LATENCY = 4
) (
  input  logic  clk,
  input  logic  reset,
  exec_unit_if.slave bus
);

  localparam int DATA_W = 32;

  if (MUL_LATENCY < 1 || MUL_LATENCY > 15) begin : g_bad_mul_latency
    $error("exec_unit: MUL_LATENCY must be in 1..15");
  end

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;

  logic [5:0]              res_tag_p1;
  logic [5:0]              res_rob_p1;
  logic [DATA_W-1:0]       res_val_p1;
  logic                    res_is_ls_p1;
  logic                    drop_err_p1;

  logic                    issue_fire;
  logic signed [DATA_W-1:0] op_a;
  logic signed [DATA_W-1:0] op_b;
  logic [DATA_W-1:0]       issue_result;

  function automatic logic [DATA_W-1:0] alu_op(
    input logic [3:0]               alu_type,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] r;
    r = '0;
    case (alu_type)
      4'd1:  r = a + b;
      4'd2:  r = a - b;
      4'd3:  r = a & b;
      4'd4:  r = a | b;
      4'd5:  r = a ^ b;
      4'd6:  r = a << b[4:0];
      4'd7:  r = $unsigned(a) >> b[4:0];
      4'd8:  r = a >>> b[4:0];
      4'd9:  r = {{(DATA_W-1){1'b0}}, (a < b)};
      4'd10: r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      4'd11: r = b;
`ifdef EXEC_MUL_EN
      // Only reaches the result register directly when MUL_LATENCY is 1.
      4'd12: r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign issue_fire   = bus.issue_valid && (state == IDLE);
  assign op_a         = $signed(bus.issue_rs1_val);
  assign op_b         = bus.issue_alusrc ? $signed(bus.issue_imm) : $signed(bus.issue_rs2_val);
  assign issue_result = bus.issue_is_LS ? (bus.issue_rs1_val + bus.issue_imm)
                                        : alu_op(bus.issue_alu_type, op_a, op_b);

`ifdef EXEC_MUL_EN
  logic signed [DATA_W-1:0] mul_a_p1;
  logic signed [DATA_W-1:0] mul_b_p1;
  logic [3:0]               mul_cnt;
  logic                     issue_is_mul;

  // The issue edge is the first of the MUL_LATENCY cycles, so BUSY covers the rest.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 1);

  assign issue_is_mul = !bus.issue_is_LS && (bus.issue_alu_type == 4'd12)
                        && (MUL_LATENCY > 1);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.issue_valid) begin
`ifdef EXEC_MUL_EN
          state_nxt = issue_is_mul ? BUSY : DONE;
`else
          state_nxt = DONE;
`endif
        end
      end
`ifdef EXEC_MUL_EN
      BUSY: if (mul_cnt == 4'd1) state_nxt = DONE;
`endif
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p1: captured op fields and the held result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_tag_p1   <= '0;
      res_rob_p1   <= '0;
      res_val_p1   <= '0;
      res_is_ls_p1 <= 1'b0;
      drop_err_p1  <= 1'b0;
`ifdef EXEC_MUL_EN
      mul_a_p1     <= '0;
      mul_b_p1     <= '0;
      mul_cnt      <= '0;
`endif
    end else begin
      if (bus.issue_valid && (state != IDLE)) drop_err_p1 <= 1'b1;
      if (issue_fire) begin
        res_tag_p1   <= bus.issue_rd_tag;
        res_rob_p1   <= bus.issue_rob_num;
        res_is_ls_p1 <= bus.issue_is_LS;
        res_val_p1   <= issue_result;
`ifdef EXEC_MUL_EN
        mul_a_p1     <= op_a;
        mul_b_p1     <= op_b;
        mul_cnt      <= MUL_CNT_INIT;
`endif
      end
`ifdef EXEC_MUL_EN
      if (state == BUSY) begin
        mul_cnt <= mul_cnt - 4'd1;
        if (mul_cnt == 4'd1) res_val_p1 <= mul_a_p1 * mul_b_p1;
      end
`endif
    end
  end

  assign bus.fu_ready    = (state == IDLE);
  assign bus.res_valid   = (state == DONE);
  assign bus.res_tag     = res_tag_p1;
  assign bus.res_rob_num = res_rob_p1;
  assign bus.res_val     = res_val_p1;
  assign bus.res_is_LS   = res_is_ls_p1;
  assign bus.drop_err    = drop_err_p1;

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit: reset, ALU ops, backpressure, LS address,
// dropped issue and MUL latency (when EXEC_MUL_EN is defined).
module tb_exec_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  exec_unit_if bus();

  exec_unit #(.MUL_LATENCY(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [3:0] t, input logic ls, input logic src,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] imm, input logic [5:0] tag,
                            input logic [5:0] rob);
    bus.issue_alu_type = t;
    bus.issue_is_LS    = ls;
    bus.issue_alusrc   = src;
    bus.issue_rs1_val  = a;
    bus.issue_rs2_val  = b;
    bus.issue_imm      = imm;
    bus.issue_rd_tag   = tag;
    bus.issue_rob_num  = rob;
  endtask

  // Issue at the next posedge, return #1 after it
  task automatic drive(input logic [3:0] t, input logic ls, input logic src,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [5:0] tag,
                       input logic [5:0] rob);
    @(negedge clk);
    set_fields(t, ls, src, a, b, imm, tag, rob);
    bus.issue_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
  endtask

  // Single-cycle op with res_ready=1: result next cycle, accepted at the following edge
  task automatic op(input string name, input logic [3:0] t, input logic src,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] imm, input logic [31:0] exp);
    drive(t, 1'b0, src, a, b, imm, 6'd1, 6'd2);
    chk({name, "_valid"}, {31'b0, bus.res_valid}, 32'd1);
    chk({name, "_val"}, bus.res_val, exp);
    @(posedge clk);
    #1;
    chk({name, "_ready_back"}, {31'b0, bus.fu_ready}, 32'd1);
  endtask

  initial begin
    bus.issue_valid = 1'b0;
    bus.res_ready   = 1'b0;
    set_fields(4'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 6'd0, 6'd0);

    #1;
    chk("rst_fu_ready", {31'b0, bus.fu_ready}, 32'd1);
    chk("rst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("rst_drop_err", {31'b0, bus.drop_err}, 32'd0);
    chk("rst_res_val", bus.res_val, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.res_ready = 1'b1;

    // ADD
    drive(4'd1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 6'd9, 6'd3);
    chk("add_valid", {31'b0, bus.res_valid}, 32'd1);
    chk("add_val", bus.res_val, 32'd12);
    chk("add_tag", {26'b0, bus.res_tag}, 32'd9);
    chk("add_rob", {26'b0, bus.res_rob_num}, 32'd3);
    chk("add_is_ls", {31'b0, bus.res_is_LS}, 32'd0);
    chk("add_fu_busy", {31'b0, bus.fu_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("add_fu_back", {31'b0, bus.fu_ready}, 32'd1);
    chk("add_accepted", {31'b0, bus.res_valid}, 32'd0);

    // SUB under backpressure, with a dropped issue in the middle
    bus.res_ready = 1'b0;
    drive(4'd2, 1'b0, 1'b0, 32'd0, 32'd1, 32'd0, 6'd4, 6'd5);
    chk("sub_val", bus.res_val, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        set_fields(4'd1, 1'b1, 1'b1, 32'd100, 32'd200, 32'd300, 6'd33, 6'd44);
        bus.issue_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.issue_valid = 1'b0;
      chk("bp_valid", {31'b0, bus.res_valid}, 32'd1);
      chk("bp_val", bus.res_val, 32'hFFFF_FFFF);
      chk("bp_fu_ready", {31'b0, bus.fu_ready}, 32'd0);
    end
    chk("drop_err_set", {31'b0, bus.drop_err}, 32'd1);
    chk("drop_tag_kept", {26'b0, bus.res_tag}, 32'd4);
    chk("drop_rob_kept", {26'b0, bus.res_rob_num}, 32'd5);
    chk("drop_ls_kept", {31'b0, bus.res_is_LS}, 32'd0);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, bus.fu_ready}, 32'd1);

    // LS address ignores alu_type
    drive(4'd3, 1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 6'd7, 6'd8);
    chk("ls_val", bus.res_val, 32'h0000_0FFC);
    chk("ls_is_ls", {31'b0, bus.res_is_LS}, 32'd1);
    @(posedge clk);
    #1;
    chk("ls_ready_back", {31'b0, bus.fu_ready}, 32'd1);

    op("sra",   4'd8,  1'b1, 32'h8000_0000, 32'd0, 32'h0000_0021, 32'hC000_0000);
    op("slt",   4'd9,  1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1);
    op("sltu",  4'd10, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    op("xor",   4'd5,  1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'h0000_0FF0);
    op("or",    4'd4,  1'b1, 32'h0000_000F, 32'd0, 32'h0000_0F00, 32'h0000_0F0F);
    op("sll",   4'd6,  1'b0, 32'h0000_0003, 32'h0000_0024, 32'd0, 32'h0000_0030);
    op("srl",   4'd7,  1'b0, 32'h8000_0000, 32'h0000_001F, 32'd0, 32'h0000_0001);
    op("passb", 4'd11, 1'b1, 32'h1111_1111, 32'd0, 32'h1234_5000, 32'h1234_5000);
    op("code0", 4'd0,  1'b0, 32'h0000_0005, 32'h0000_0007, 32'd0, 32'd0);
    op("code14", 4'd14, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'd0, 32'd0);

    // Asynchronous reset while holding a result
    bus.res_ready = 1'b0;
    drive(4'd1, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 6'd10, 6'd11);
    chk("arst_pre_valid", {31'b0, bus.res_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_fu_ready", {31'b0, bus.fu_ready}, 32'd1);
    chk("arst_res_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("arst_drop_err", {31'b0, bus.drop_err}, 32'd0);
    chk("arst_res_val", bus.res_val, 32'd0);
    chk("arst_res_tag", {26'b0, bus.res_tag}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.res_ready = 1'b1;

`ifdef EXEC_MUL_EN
    // Reset in BUSY aborts the multiply
    drive(4'd12, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0001, 32'd0, 6'd5, 6'd6);
    chk("mul_busy_valid", {31'b0, bus.res_valid}, 32'd0);
    chk("mul_busy_ready", {31'b0, bus.fu_ready}, 32'd0);
    reset = 1'b1;
    #1;
    chk("mul_arst_ready", {31'b0, bus.fu_ready}, 32'd1);
    chk("mul_arst_valid", {31'b0, bus.res_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // MUL latency 4 with a dropped issue during BUSY
    drive(4'd12, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0001, 32'd0, 6'd5, 6'd6);
    chk("mul_n1_valid", {31'b0, bus.res_valid}, 32'd0);
    drive(4'd1, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0, 6'd20, 6'd21);
    chk("mul_drop_err", {31'b0, bus.drop_err}, 32'd1);
    chk("mul_n2_valid", {31'b0, bus.res_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("mul_n3_valid", {31'b0, bus.res_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("mul_n4_valid", {31'b0, bus.res_valid}, 32'd1);
    chk("mul_val", bus.res_val, 32'h0001_0000);
    chk("mul_tag", {26'b0, bus.res_tag}, 32'd5);
    chk("mul_rob", {26'b0, bus.res_rob_num}, 32'd6);
    @(posedge clk);
    #1;
    chk("mul_ready_back", {31'b0, bus.fu_ready}, 32'd1);
`else
    op("mul_off", 4'd12, 1'b0, 32'h0001_0000, 32'h0001_0001, 32'd0, 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
